// File: rtl/mem_access_stage.sv
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Issues loads and stores to a variable-latency data memory over a
//            req/ack handshake. Stalls upstream while an access is
//            outstanding. Registers the result, the load data and the
//            destination info into the MA pipeline register.
// Ports    : clk, rst                      - clock, async active-high reset
//            valid_ex, ctrl_ex, res_ex,
//            reg_data_ex, dest_idx_ex,
//            dest_we_ex                    - instruction from EX
//            mem_req, mem_we, mem_addr,
//            mem_wdata, mem_rdata, mem_ack - data-memory handshake
//            stall_ma                      - upstream freeze (combinational)
//            valid_ma, ctrl_ma, res_ma,
//            data_ma, dest_idx_ma,
//            dest_we_ma, err_ma            - MA pipeline register
// Options  : `define MA_TIMEOUT_EN to abort an access that waits MAX_WAIT
//            cycles without ack (commits with err_ma=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                IDX_W    = 5,
  parameter int                CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] LOAD_OP  = 4'b1100,
  parameter logic [CTRL_W-1:0] STORE_OP = 4'b1110,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_ex,
  input  logic [CTRL_W-1:0] ctrl_ex,
  input  logic [DATA_W-1:0] res_ex,
  input  logic [DATA_W-1:0] reg_data_ex,
  input  logic [IDX_W-1:0]  dest_idx_ex,
  input  logic              dest_we_ex,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_ma,
  output logic              valid_ma,
  output logic [CTRL_W-1:0] ctrl_ma,
  output logic [DATA_W-1:0] res_ma,
  output logic [DATA_W-1:0] data_ma,
  output logic [IDX_W-1:0]  dest_idx_ma,
  output logic              dest_we_ma,
  output logic              err_ma
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;

  // Hold register: the memory op being waited on
  logic [CTRL_W-1:0] hold_ctrl_q,  hold_ctrl_d;
  logic [DATA_W-1:0] hold_res_q,   hold_res_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [IDX_W-1:0]  hold_idx_q,   hold_idx_d;
  logic              hold_we_q,    hold_we_d;

  // MA pipeline register
  logic              valid_ma_q,    valid_ma_d;
  logic [CTRL_W-1:0] ctrl_ma_q,     ctrl_ma_d;
  logic [DATA_W-1:0] res_ma_q,      res_ma_d;
  logic [DATA_W-1:0] data_ma_q,     data_ma_d;
  logic [IDX_W-1:0]  dest_idx_ma_q, dest_idx_ma_d;
  logic              dest_we_ma_q,  dest_we_ma_d;
  logic              err_ma_q,      err_ma_d;

  logic              w_is_load_ex;
  logic              w_is_store_ex;
  logic              w_mop_ex;
  logic              w_hold_store;
  logic              w_timeout;
  logic              w_mem_req;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_stall;

  assign w_is_load_ex  = (ctrl_ex == LOAD_OP);
  assign w_is_store_ex = (ctrl_ex == STORE_OP);
  assign w_mop_ex      = valid_ex && (w_is_load_ex || w_is_store_ex);
  assign w_hold_store  = (hold_ctrl_q == STORE_OP);

`ifdef MA_TIMEOUT_EN
  localparam int                CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  C_MAX_WAIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // An ack arriving on the limit cycle takes priority over the abort
  assign w_timeout = (state_q == ST_WAIT) && (wait_cnt_q == C_MAX_WAIT) && !mem_ack;

  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == ST_WAIT) && !mem_ack && !w_timeout) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic w_unused_max_wait;
  assign w_timeout         = 1'b0;
  assign w_unused_max_wait = (MAX_WAIT > 0);
`endif

  always_comb begin
    state_d       = state_q;
    hold_ctrl_d   = hold_ctrl_q;
    hold_res_d    = hold_res_q;
    hold_wdata_d  = hold_wdata_q;
    hold_idx_d    = hold_idx_q;
    hold_we_d     = hold_we_q;

    valid_ma_d    = 1'b0;
    ctrl_ma_d     = ctrl_ex;
    res_ma_d      = res_ex;
    data_ma_d     = '0;
    dest_idx_ma_d = dest_idx_ex;
    dest_we_ma_d  = 1'b0;
    err_ma_d      = 1'b0;

    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = '0;
    w_mem_wdata   = '0;
    w_stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_ma_d   = valid_ex;
        dest_we_ma_d = dest_we_ex;
        if (w_mop_ex) begin
          w_mem_req   = 1'b1;
          w_mem_we    = w_is_store_ex;
          w_mem_addr  = res_ex[ADDR_W-1:0];
          w_mem_wdata = w_is_store_ex ? reg_data_ex : '0;
          if (mem_ack) begin
            data_ma_d    = w_is_store_ex ? '0 : mem_rdata;
            dest_we_ma_d = w_is_store_ex ? 1'b0 : dest_we_ex;
          end else begin
            // Park the op and insert a bubble until memory answers
            w_stall      = 1'b1;
            state_d      = ST_WAIT;
            hold_ctrl_d  = ctrl_ex;
            hold_res_d   = res_ex;
            hold_wdata_d = reg_data_ex;
            hold_idx_d   = dest_idx_ex;
            hold_we_d    = dest_we_ex;
            valid_ma_d   = 1'b0;
            dest_we_ma_d = 1'b0;
          end
        end
      end

      ST_WAIT: begin
        // EX is frozen; everything comes from the hold register
        ctrl_ma_d     = hold_ctrl_q;
        res_ma_d      = hold_res_q;
        dest_idx_ma_d = hold_idx_q;
        w_mem_req     = !w_timeout;
        w_mem_we      = w_mem_req && w_hold_store;
        w_mem_addr    = w_mem_req ? hold_res_q[ADDR_W-1:0] : '0;
        w_mem_wdata   = (w_mem_req && w_hold_store) ? hold_wdata_q : '0;
        if (mem_ack) begin
          state_d      = ST_IDLE;
          valid_ma_d   = 1'b1;
          data_ma_d    = w_hold_store ? '0 : mem_rdata;
          dest_we_ma_d = w_hold_store ? 1'b0 : hold_we_q;
        end else if (w_timeout) begin
          state_d      = ST_IDLE;
          valid_ma_d   = 1'b1;
          err_ma_d     = 1'b1;
        end else begin
          w_stall      = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_ctrl_q   <= '0;
      hold_res_q    <= '0;
      hold_wdata_q  <= '0;
      hold_idx_q    <= '0;
      hold_we_q     <= 1'b0;
      valid_ma_q    <= 1'b0;
      ctrl_ma_q     <= '0;
      res_ma_q      <= '0;
      data_ma_q     <= '0;
      dest_idx_ma_q <= '0;
      dest_we_ma_q  <= 1'b0;
      err_ma_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_ctrl_q   <= hold_ctrl_d;
      hold_res_q    <= hold_res_d;
      hold_wdata_q  <= hold_wdata_d;
      hold_idx_q    <= hold_idx_d;
      hold_we_q     <= hold_we_d;
      valid_ma_q    <= valid_ma_d;
      ctrl_ma_q     <= ctrl_ma_d;
      res_ma_q      <= res_ma_d;
      data_ma_q     <= data_ma_d;
      dest_idx_ma_q <= dest_idx_ma_d;
      dest_we_ma_q  <= dest_we_ma_d;
      err_ma_q      <= err_ma_d;
    end
  end

  // Combinational outputs are forced quiet during reset so an in-flight
  // request is dropped the moment rst rises.
  assign mem_req     = w_mem_req & ~rst;
  assign mem_we      = w_mem_we & ~rst;
  assign mem_addr    = rst ? '0 : w_mem_addr;
  assign mem_wdata   = rst ? '0 : w_mem_wdata;
  assign stall_ma    = w_stall & ~rst;

  assign valid_ma    = valid_ma_q;
  assign ctrl_ma     = ctrl_ma_q;
  assign res_ma      = res_ma_q;
  assign data_ma     = data_ma_q;
  assign dest_idx_ma = dest_idx_ma_q;
  assign dest_we_ma  = dest_we_ma_q;
  assign err_ma      = err_ma_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed self-checking bench for mem_access_stage. Expected
//            commits are queued when an instruction is driven and popped by
//            a monitor whenever valid_ma is seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam logic [3:0] LD  = 4'b1100;
  localparam logic [3:0] ST  = 4'b1110;
  localparam logic [3:0] ALU = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_ex;
  logic [3:0]  ctrl_ex;
  logic [15:0] res_ex;
  logic [15:0] reg_data_ex;
  logic [4:0]  dest_idx_ex;
  logic        dest_we_ex;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_ma;
  logic        valid_ma;
  logic [3:0]  ctrl_ma;
  logic [15:0] res_ma;
  logic [15:0] data_ma;
  logic [4:0]  dest_idx_ma;
  logic        dest_we_ma;
  logic        err_ma;

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [15:0] r;
    logic [15:0] d;
    logic [4:0]  i;
    logic        w;
    logic        e;
  } exp_t;

  exp_t sb[$];
  exp_t act;
  int   n_cmp = 0;
  int   n_err = 0;

  assign act = {valid_ma, ctrl_ma, res_ma, data_ma, dest_idx_ma, dest_we_ma, err_ma};

  mem_access_stage #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .IDX_W   (5),
    .CTRL_W  (4),
    .LOAD_OP (LD),
    .STORE_OP(ST),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_ex   (valid_ex),
    .ctrl_ex    (ctrl_ex),
    .res_ex     (res_ex),
    .reg_data_ex(reg_data_ex),
    .dest_idx_ex(dest_idx_ex),
    .dest_we_ex (dest_we_ex),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_ma   (stall_ma),
    .valid_ma   (valid_ma),
    .ctrl_ma    (ctrl_ma),
    .res_ma     (res_ma),
    .data_ma    (data_ma),
    .dest_idx_ma(dest_idx_ma),
    .dest_we_ma (dest_we_ma),
    .err_ma     (err_ma)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [15:0] r, input logic [15:0] d,
                          input logic [4:0] ix, input logic w, input logic e);
    exp_t x;
    x = {1'b1, c, r, d, ix, w, e};
    sb.push_back(x);
  endtask

  task automatic drive_ex(input logic v, input logic [3:0] c, input logic [15:0] r,
                          input logic [15:0] wd, input logic [4:0] ix, input logic w);
    valid_ex    = v;
    ctrl_ex     = c;
    res_ex      = r;
    reg_data_ex = wd;
    dest_idx_ex = ix;
    dest_we_ex  = w;
  endtask

  // Non-memory instruction; a stray ack must be ignored
  task automatic alu_op(input logic v, input logic [3:0] c, input logic [15:0] r,
                        input logic [4:0] ix, input logic w, input logic stray_ack);
    @(negedge clk);
    drive_ex(v, c, r, 16'h7777, ix, w);
    mem_ack   = stray_ack;
    mem_rdata = 16'hFFFF;
    #1;
    chk("alu_req", mem_req, 1'b0);
    chk("alu_stall", stall_ma, 1'b0);
    if (v) push_exp(c, r, 16'h0000, ix, w, 1'b0);
    @(posedge clk);
    #1;
    if (!v) chk("alu_bubble", valid_ma, 1'b0);
    mem_ack = 1'b0;
  endtask

  // Memory op acked nwait cycles after the first request
  task automatic mem_op(input logic [3:0] c, input logic [15:0] r, input logic [15:0] wd,
                        input logic [4:0] ix, input logic w, input int nwait,
                        input logic [15:0] rd);
    logic is_st;
    is_st = (c == ST);
    @(negedge clk);
    drive_ex(1'b1, c, r, wd, ix, w);
    for (int i = 0; i <= nwait; i++) begin
      if (i > 0) @(negedge clk);
      mem_ack   = (i == nwait);
      mem_rdata = (i == nwait) ? rd : 16'hDEAD;
      #1;
      chk("mop_req", mem_req, 1'b1);
      chk("mop_we", mem_we, is_st);
      chk("mop_addr", mem_addr, r);
      chk("mop_wdata", mem_wdata, is_st ? wd : 16'h0000);
      chk("mop_stall", stall_ma, (i < nwait));
      if (i == nwait) push_exp(c, r, is_st ? 16'h0000 : rd, ix, is_st ? 1'b0 : w, 1'b0);
      @(posedge clk);
      #1;
      if (i < nwait) begin
        chk("mop_bubble_v", valid_ma, 1'b0);
        chk("mop_bubble_we", dest_we_ma, 1'b0);
      end
    end
    mem_ack = 1'b0;
  endtask

  // Commit monitor: every valid_ma must match the oldest queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid_ma) begin
      if (sb.size() == 0) begin
        chk("commit_unexpected", act, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("commit", act, e);
      end
    end
  end

  initial begin
    drive_ex(1'b0, 4'h0, 16'h0000, 16'h0000, 5'd0, 1'b0);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;

    // Reset state
    #2;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", stall_ma, 1'b0);
    chk("rst_ma", act, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // ALU passthrough, with a stray ack while no request is out
    alu_op(1'b1, ALU, 16'h1234, 5'd3, 1'b1, 1'b1);
    // Invalid load in EX must not request
    alu_op(1'b0, LD, 16'h0044, 5'd1, 1'b1, 1'b0);

    // Zero-wait load
    mem_op(LD, 16'h0040, 16'h1111, 5'd5, 1'b1, 0, 16'hBEEF);
    // Three-wait store
    mem_op(ST, 16'h0010, 16'h00AA, 5'd7, 1'b1, 3, 16'h0000);
    // Back-to-back load then store, each acked on its 2nd cycle
    mem_op(LD, 16'h0020, 16'h0000, 5'd9, 1'b1, 1, 16'h1357);
    mem_op(ST, 16'h0030, 16'h55AA, 5'd2, 1'b1, 1, 16'h0000);
    alu_op(1'b1, ALU, 16'h0BAD, 5'd8, 1'b0, 1'b0);

    // Reset in the middle of a wait drops the request and loses the op
    @(negedge clk);
    drive_ex(1'b1, LD, 16'h0080, 16'h0000, 5'd4, 1'b1);
    #1;
    chk("rw_req0", mem_req, 1'b1);
    chk("rw_stall0", stall_ma, 1'b1);
    @(negedge clk);
    #1;
    chk("rw_req1", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_req_rst", mem_req, 1'b0);
    chk("rw_stall_rst", stall_ma, 1'b0);
    chk("rw_ma_rst", act, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_ex(1'b0, 4'h0, 16'h0000, 16'h0000, 5'd0, 1'b0);
    alu_op(1'b1, ALU, 16'h4321, 5'd11, 1'b1, 1'b0);

`ifdef MA_TIMEOUT_EN
    // Load never acked: request drops after MAX_WAIT wait cycles
    @(negedge clk);
    drive_ex(1'b1, LD, 16'h0090, 16'h0000, 5'd6, 1'b1);
    mem_ack = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("to_req", mem_req, (i < 5));
      chk("to_stall", stall_ma, (i < 5));
      if (i == 5) push_exp(LD, 16'h0090, 16'h0000, 5'd6, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      if (i < 5) chk("to_bubble", valid_ma, 1'b0);
    end
    alu_op(1'b1, ALU, 16'h5A5A, 5'd12, 1'b1, 1'b0);
`endif

    @(negedge clk);
    drive_ex(1'b0, 4'h0, 16'h0000, 16'h0000, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
